// File: rtl/tx_top_if.sv
// Word handshake between a producer and the UART transmit path.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

interface tx_top_if #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] TX_DATA;
  logic                  TX_VALID;
  logic                  TX_READY;

  modport master (
    output TX_DATA,
    output TX_VALID,
    input  TX_READY
  );

  modport slave (
    input  TX_DATA,
    input  TX_VALID,
    output TX_READY
  );
endinterface

// File: rtl/tx_top.sv
// UART transmit path: start bit, DATA_WIDTH data bits LSB-first, parity, stop.
// One bit per TX_CLK cycle; every output is driven straight from a register.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module tx_top #(
  parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic    TX_CLK,
  input  logic    RST,
  tx_top_if.slave tx,
  output logic    TX_OUT,
  output logic    TX_BUSY,
  output logic    TX_DONE
);

  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("tx_top: DATA_WIDTH must lie in 5..9");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [CW-1:0]         bit_cnt;
  logic                  parity_q;
  logic                  out_q;
  logic                  ready_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  accept;

  assign accept      = tx.TX_VALID && ready_q;
  assign tx.TX_READY = ready_q;
  assign TX_OUT      = out_q;
  assign TX_BUSY     = busy_q;
  assign TX_DONE     = done_q;

  // Outputs are loaded with the value for the state being entered, so the
  // line always reflects the current state without a combinational path.
  always_ff @(posedge TX_CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      parity_q <= 1'b0;
      out_q    <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE, STOP: begin
          if (accept) begin
            state    <= START;
            shreg    <= tx.TX_DATA;
            parity_q <= (^tx.TX_DATA) ^ PARITY_ODD;
            bit_cnt  <= '0;
            out_q    <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
          end else begin
            state   <= IDLE;
            out_q   <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          out_q   <= shreg[0];
          shreg   <= shreg >> 1;
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            state <= PARITY;
            out_q <= parity_q;
          end else begin
            out_q   <= shreg[0];
            shreg   <= shreg >> 1;
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          state   <= STOP;
          out_q   <= 1'b1;
          done_q  <= 1'b1;
          ready_q <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          out_q   <= 1'b1;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_top.sv
// Scoreboard bench for tx_top: even- and odd-parity instances share stimulus,
// expected line cycles are queued on accept and popped by a negedge monitor.
module tb_tx_top;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  tx_top_if #(.DATA_WIDTH(W)) if_e ();
  tx_top_if #(.DATA_WIDTH(W)) if_o ();

  logic out_e, busy_e, done_e;
  logic out_o, busy_o, done_o;

  tx_top #(.DATA_WIDTH(W), .PARITY_ODD(1'b0)) dut_e (
    .TX_CLK (clk),
    .RST    (rst),
    .tx     (if_e.slave),
    .TX_OUT (out_e),
    .TX_BUSY(busy_e),
    .TX_DONE(done_e)
  );

  tx_top #(.DATA_WIDTH(W), .PARITY_ODD(1'b1)) dut_o (
    .TX_CLK (clk),
    .RST    (rst),
    .tx     (if_o.slave),
    .TX_OUT (out_o),
    .TX_BUSY(busy_o),
    .TX_DONE(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic out_e;
    logic out_o;
    logic done;
  } rec_t;

  rec_t        exp_q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Whole frame as line values, one entry per bit time.
  function automatic void push_frame(input logic [W-1:0] d);
    int unsigned ones;
    rec_t        r;
    ones = 0;
    r.done  = 1'b0;
    r.out_e = 1'b0;
    r.out_o = 1'b0;
    exp_q.push_back(r);
    for (int i = 0; i < W; i++) begin
      if (d[i]) ones++;
      r.out_e = d[i];
      r.out_o = d[i];
      exp_q.push_back(r);
    end
    r.out_e = (ones % 2) == 1;
    r.out_o = (ones % 2) == 0;
    exp_q.push_back(r);
    r.out_e = 1'b1;
    r.out_o = 1'b1;
    r.done  = 1'b1;
    exp_q.push_back(r);
  endfunction

  always @(negedge clk) begin : monitor
    rec_t r;
    bit   in_frame;
    in_frame = exp_q.size() > 0;
    if (in_frame) r = exp_q.pop_front();
    else begin
      r.out_e = 1'b1;
      r.out_o = 1'b1;
      r.done  = 1'b0;
    end
    check("out_even",   out_e,          r.out_e);
    check("out_odd",    out_o,          r.out_o);
    check("busy_even",  busy_e,         in_frame);
    check("busy_odd",   busy_o,         in_frame);
    check("done_even",  done_e,         r.done);
    check("done_odd",   done_o,         r.done);
    check("ready_even", if_e.TX_READY,  exp_q.size() == 0);
    check("ready_odd",  if_o.TX_READY,  exp_q.size() == 0);
  end

  // One bit time of stimulus; the model accepts only when no frame is pending
  // beyond the current cycle (idle or stop bit on the line).
  task automatic cyc(input logic v, input logic [W-1:0] d);
    if_e.TX_VALID = v;
    if_e.TX_DATA  = d;
    if_o.TX_VALID = v;
    if_o.TX_DATA  = d;
    @(posedge clk);
    if (v && !rst && exp_q.size() == 0) push_frame(d);
    #1;
  endtask

  task automatic do_reset(input int unsigned n);
    rst = 1'b1;
    #1;
    check("rst_out_even",  out_e,  1'b1);
    check("rst_out_odd",   out_o,  1'b1);
    check("rst_busy_even", busy_e, 1'b0);
    check("rst_busy_odd",  busy_o, 1'b0);
    check("rst_done_even", done_e, 1'b0);
    check("rst_done_odd",  done_o, 1'b0);
    check("rst_ready",     if_e.TX_READY, 1'b1);
    exp_q.delete();
    repeat (n) cyc(1'b0, '0);
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stimulus
    logic         v;
    logic [W-1:0] d;
    if_e.TX_VALID = 1'b0;
    if_e.TX_DATA  = '0;
    if_o.TX_VALID = 1'b0;
    if_o.TX_DATA  = '0;
    #1;
    do_reset(3);

    repeat (50) cyc(1'b0, '0);

    cyc(1'b1, 8'hA5);
    repeat (14) cyc(1'b0, '0);

    cyc(1'b1, 8'h07);
    repeat (14) cyc(1'b0, '0);

    cyc(1'b1, 8'h00);
    repeat (11) cyc(1'b1, 8'hFF);
    repeat (14) cyc(1'b0, '0);

    cyc(1'b1, 8'h3C);
    for (int i = 0; i < 11; i++) cyc(1'b1, (i % 2) ? 8'hFF : 8'h5A);
    repeat (14) cyc(1'b0, '0);

    cyc(1'b1, 8'h55);
    repeat (4) cyc(1'b0, '0);
    do_reset(2);
    cyc(1'b1, 8'h01);
    repeat (14) cyc(1'b0, '0);

    repeat (500) begin
      v = $urandom_range(0, 3) != 0;
      d = W'($urandom);
      cyc(v, d);
      if ($urandom_range(0, 149) == 0) do_reset(1);
    end
    repeat (14) cyc(1'b0, '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_top.md
Name: tx_top

Overview:
UART transmit path, the counterpart of the receive path. It accepts a parallel word through a valid/ready handshake. It then serialises one frame on TX_OUT: start bit, data LSB-first, parity bit, stop bit. Each bit lasts exactly one TX_CLK cycle, so TX_CLK is the bit clock shared with the far-end RX_CLK domain. The block contains a frame FSM, a PISO shift register, a bit counter and a parity generator.

Parameters:
DATA_WIDTH, `DATA_WIDTH (8), number of data bits per frame; legal range 5..9.
PARITY_ODD, 0, 0 = even parity (parity bit = XOR of data bits); 1 = odd parity (inverted XOR).

Ports:
TX_CLK  input  1  bit clock; all state updates on its rising edge.
RST  input  1  asynchronous, active-high reset.
TX_DATA  input  DATA_WIDTH  word to send; sampled only on an accept cycle.
TX_VALID  input  1  TX_DATA is valid.
TX_READY  output  1  block can accept a word this cycle.
TX_OUT  output  1  serial line; idles high.
TX_BUSY  output  1  frame in progress (any state other than IDLE).
TX_DONE  output  1  one-cycle pulse during the stop-bit cycle of each frame.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - State goes to IDLE.
  - TX_OUT=1, TX_READY=1, TX_BUSY=0, TX_DONE=0.
  - Shift register and bit counter clear to 0.
- Accept rule: a word is accepted on a rising edge when TX_VALID && TX_READY. TX_DATA is captured into the shift register on that edge. The parity bit is computed from TX_DATA on the same edge and registered.
- FSM states and transitions:
  - IDLE: TX_OUT=1, TX_READY=1. On accept, go to START.
  - START: TX_OUT=0, one cycle, then go to DATA. Bit counter set to 0.
  - DATA: TX_OUT = shift register bit 0. Shift right each cycle. Bit counter increments. After DATA_WIDTH cycles, go to PARITY.
  - PARITY: TX_OUT = registered parity bit, one cycle, then go to STOP.
  - STOP: TX_OUT=1 for one cycle; TX_DONE=1; TX_READY=1.
    - Accept in STOP: go directly to START (back-to-back frames, no idle gap).
    - No accept in STOP: go to IDLE.
- TX_READY is 0 in START, DATA and PARITY. TX_VALID in those states is ignored; the word is neither captured nor queued.
- TX_OUT is driven from a register: no combinational path from any input to TX_OUT.
- Latency:
  - Start bit appears on TX_OUT in the cycle after the accept edge.
  - Frame length is DATA_WIDTH+3 cycles.
  - Accepting in every STOP cycle gives a sustained throughput of one word per DATA_WIDTH+3 cycles.
- Changes to TX_DATA after the accept edge have no effect on the frame in flight.
- Reset asserted mid-frame aborts the frame. TX_OUT returns high asynchronously and no TX_DONE is issued. The first accept after reset release starts a clean frame.
- TX_BUSY=1 in START, DATA, PARITY and STOP. It stays 1 through back-to-back frames and falls only on entering IDLE.
- The bit counter is wide enough for DATA_WIDTH-1 ($clog2(DATA_WIDTH) bits). The DATA exit compares against DATA_WIDTH-1 and never wraps past it.

Test Plan:
- Reset, then TX_VALID=1 with TX_DATA=8'hA5 in IDLE:
  - Starting the next cycle, TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop).
  - TX_DONE high in the 11th cycle only.
  - Then TX_OUT stays 1 and TX_BUSY=0.
- TX_DATA=8'h07 (three ones):
  - PARITY_ODD=0: parity bit = 1.
  - Rerun with PARITY_ODD=1: parity bit = 0; all other bits unchanged.
- Back-to-back: send 8'h00, with TX_VALID held high and TX_DATA=8'hFF presented during the first frame's STOP:
  - TX_OUT = 0,00000000,0,1,0,11111111,0,1 over 22 contiguous cycles.
  - TX_BUSY stays high throughout; TX_DONE pulses at cycles 11 and 22.
- Send 8'h3C, then during its DATA cycles raise TX_VALID with 8'hFF and toggle TX_DATA:
  - TX_READY=0 throughout; the frame carries 8'h3C unchanged.
  - The held TX_VALID is accepted in STOP, so the next frame carries the value present on that cycle.
- Assert RST during the 4th data bit of 8'h55:
  - TX_OUT=1 and TX_BUSY=0 immediately, with no TX_DONE.
  - After release, sending 8'h01 gives 0,1,0000000,1,1.
- TX_VALID held low for 50 cycles after reset: TX_OUT=1, TX_READY=1, TX_BUSY=0 and TX_DONE=0 throughout.
